// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer_bank register map: word offsets, bit
// positions and the per-channel write-strobe bundle.
package timer_bank_pkg;

  localparam logic [2:0] W_STATUS   = 3'd0;
  localparam logic [2:0] W_CONTROL  = 3'd1;
  localparam logic [2:0] W_PERIOD_L = 3'd2;
  localparam logic [2:0] W_PERIOD_H = 3'd3;
  localparam logic [2:0] W_SNAP_L   = 3'd4;
  localparam logic [2:0] W_SNAP_H   = 3'd5;

  localparam int CTRL_IE    = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  typedef struct packed {
    logic status;
    logic control;
    logic period_l;
    logic period_h;
    logic snap;
  } ch_wr_t;

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: down-counter, period, snapshot, control bits, sticky
// timeout with registered zero-edge detect, and its read word mux.
module timer_bank_channel
  import timer_bank_pkg::*;
#(
  parameter int          COUNT_W        = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  ch_wr_t      wr,
  input  logic [15:0] writedata,
  input  logic [2:0]  rd_word,
  output logic [15:0] rd_data,
  output logic        irq
);

  localparam logic [COUNT_W-1:0] RST_PERIOD = COUNT_W'(DEFAULT_PERIOD);
  localparam logic               RST_ZERO   = (DEFAULT_PERIOD == 0);

  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic ie_q, ie_d, cont_q, cont_d, run_q, run_d, to_q, to_d;
  logic reload_q, reload_d, zero_q, zero_d, zero_prev_q, zero_prev_d;
  logic start, stop, evt;

  always_comb begin
    start       = wr.control & writedata[CTRL_START];
    stop        = wr.control & writedata[CTRL_STOP];
    evt         = zero_q & ~zero_prev_q;
    period_d    = period_q;
    ie_d        = ie_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    to_d        = to_q;
    snap_d      = snap_q;
    reload_d    = wr.period_l | wr.period_h;
    zero_d      = (cnt_q == '0);
    zero_prev_d = zero_q;

    if (wr.period_l) period_d[15:0]         = writedata;
    if (wr.period_h) period_d[COUNT_W-1:16] = writedata[COUNT_W-17:0];
    if (wr.control) begin
      ie_d   = writedata[CTRL_IE];
      cont_d = writedata[CTRL_CONT];
    end

    // A pending reload overrides counting; START still wins over the RUN clear.
    if (reload_q) begin
      cnt_d = period_q;
      run_d = 1'b0;
    end else if (run_q && tick) begin
      if (cnt_q == '0) begin
        cnt_d = period_q;
        if (!cont_q) run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - COUNT_W'(1);
      end
    end
    if (stop)  run_d = 1'b0;
    if (start) run_d = 1'b1;

    if (wr.snap)   snap_d = cnt_q;
    if (wr.status) to_d   = 1'b0;
    if (evt)       to_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= RST_PERIOD;
      period_q    <= RST_PERIOD;
      snap_q      <= '0;
      ie_q        <= 1'b0;
      cont_q      <= 1'b0;
      run_q       <= 1'b0;
      to_q        <= 1'b0;
      reload_q    <= 1'b0;
      zero_q      <= RST_ZERO;
      zero_prev_q <= RST_ZERO;
    end else begin
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      snap_q      <= snap_d;
      ie_q        <= ie_d;
      cont_q      <= cont_d;
      run_q       <= run_d;
      to_q        <= to_d;
      reload_q    <= reload_d;
      zero_q      <= zero_d;
      zero_prev_q <= zero_prev_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_word)
      W_STATUS: begin
        rd_data[STAT_TO]  = to_q;
        rd_data[STAT_RUN] = run_q;
      end
      W_CONTROL: begin
        rd_data[CTRL_IE]   = ie_q;
        rd_data[CTRL_CONT] = cont_q;
      end
      W_PERIOD_L: rd_data = period_q[15:0];
      W_PERIOD_H: rd_data = 16'(period_q[COUNT_W-1:16]);
      W_SNAP_L:   rd_data = snap_q[15:0];
      W_SNAP_H:   rd_data = 16'(snap_q[COUNT_W-1:16]);
      default:    rd_data = '0;
    endcase
  end

  assign irq = to_q & ie_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel interval timer on a 16-bit Avalon-MM slave: shared prescaler,
// address decode, registered read mux and combined interrupt.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          COUNT_W        = 32,
  parameter int          PRESCALE       = 1,
  parameter int unsigned DEFAULT_PERIOD = 49999
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_CH)+2:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [15:0]                 writedata,
  output logic [15:0]                 readdata,
  output logic [NUM_CH-1:0]           irq_vec,
  output logic                        irq
);

  localparam int AW    = $clog2(NUM_CH) + 3;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [15:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic [AW-1:0]    ch_idx;
  logic [2:0]       word;
  logic [15:0]      ch_rdata [NUM_CH];

  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  assign wr_en  = chipselect & ~write_n;
  assign ch_idx = address >> 3;
  assign word   = address[2:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic   sel;
    ch_wr_t wr_s;

    assign sel  = wr_en && (ch_idx == AW'(i));
    assign wr_s = '{status:   sel && (word == W_STATUS),
                    control:  sel && (word == W_CONTROL),
                    period_l: sel && (word == W_PERIOD_L),
                    period_h: sel && (word == W_PERIOD_H),
                    snap:     sel && ((word == W_SNAP_L) || (word == W_SNAP_H))};

    timer_bank_channel #(
      .COUNT_W        (COUNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .wr        (wr_s),
      .writedata (writedata),
      .rd_word   (word),
      .rd_data   (ch_rdata[i]),
      .irq       (irq_vec[i])
    );
  end

  // Unpopulated channel slots fall through to zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == AW'(i)) readdata_d = ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q      <= '0;
      readdata_q <= '0;
    end else begin
      pre_q      <= pre_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: one instance with PRESCALE=1 and one with
// PRESCALE=4 sharing the clock, reset and address/data bus.
module tb_timer_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        cs4 = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata, readdata4;
  logic [3:0]  irq_vec, irq_vec4;
  logic        irq, irq4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_rst  [6] = '{16'h0000, 16'h0000, 16'hC34F, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] exp_snap [7] = '{16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2};

  timer_bank #(.NUM_CH(4), .COUNT_W(32), .PRESCALE(1), .DEFAULT_PERIOD(49999)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq)
  );

  timer_bank #(.NUM_CH(4), .COUNT_W(32), .PRESCALE(4), .DEFAULT_PERIOD(49999)) dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4),
    .irq_vec(irq_vec4), .irq(irq4)
  );

  always #5 clk = ~clk;

  // Edges seen with reset released; tick edges of the PRESCALE=4 instance are multiples of 4.
  always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic wr(input bit to4, input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    if (to4) cs4 = 1'b1; else chipselect = 1'b1;
    @(posedge clk); #1;
    write_n = 1'b1; chipselect = 1'b0; cs4 = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge clk);
    address = a;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if (readdata !== 16'h0) begin errors++; $display("FAIL rst_readdata: got %h expected %h", readdata, 16'h0); end
    checks++; if (irq !== 1'b0 || irq4 !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b/%b expected 0/0", irq, irq4); end
    checks++; if (irq_vec !== 4'b0) begin errors++; $display("FAIL rst_irq_vec: got %b expected %b", irq_vec, 4'b0); end
    @(negedge clk); reset_n = 1'b1;
    for (int w = 0; w < 6; w++) begin
      rd(5'(w));
      checks++; if (readdata !== exp_rst[w]) begin errors++; $display("FAIL rst_word%0d: got %h expected %h", w, readdata, exp_rst[w]); end
      checks++; if (readdata4 !== exp_rst[w]) begin errors++; $display("FAIL rst4_word%0d: got %h expected %h", w, readdata4, exp_rst[w]); end
    end
  endtask

  task automatic test_oneshot();
    wr(0, 5'd10, 16'd10);
    wr(0, 5'd11, 16'd0);
    wr(0, 5'd9, 16'h0005);
    repeat (11) @(posedge clk); #1;
    checks++; if (irq_vec !== 4'b0000) begin errors++; $display("FAIL oneshot_early: got %b expected %b", irq_vec, 4'b0000); end
    @(posedge clk); #1;
    checks++; if (irq_vec !== 4'b0010) begin errors++; $display("FAIL oneshot_irq_vec: got %b expected %b", irq_vec, 4'b0010); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq: got %b expected 1", irq); end
    rd(5'd8);
    checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL oneshot_status: got %h expected %h", readdata, 16'h0001); end
    wr(0, 5'd8, 16'h0000);
    checks++; if (irq_vec !== 4'b0000 || irq !== 1'b0) begin errors++; $display("FAIL oneshot_clear: got %b/%b expected 0000/0", irq_vec, irq); end
  endtask

  task automatic test_continuous();
    wr(0, 5'd18, 16'd3);
    wr(0, 5'd19, 16'd0);
    wr(0, 5'd17, 16'h0007);
    repeat (4) @(posedge clk); #1;
    checks++; if (irq_vec[2] !== 1'b0) begin errors++; $display("FAIL cont_pre_event: got %b expected 0", irq_vec[2]); end
    @(posedge clk); #1;
    checks++; if (irq_vec[2] !== 1'b1) begin errors++; $display("FAIL cont_event1: got %b expected 1", irq_vec[2]); end
    wr(0, 5'd16, 16'h0000);
    checks++; if (irq_vec[2] !== 1'b0) begin errors++; $display("FAIL cont_clear: got %b expected 0", irq_vec[2]); end
    repeat (2) @(posedge clk);
    wr(0, 5'd16, 16'h0000);
    checks++; if (irq_vec[2] !== 1'b1) begin errors++; $display("FAIL cont_clear_vs_event: got %b expected 1", irq_vec[2]); end
    rd(5'd16);
    checks++; if (readdata !== 16'h0003) begin errors++; $display("FAIL cont_status: got %h expected %h", readdata, 16'h0003); end
    wr(0, 5'd17, 16'h0008);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_stop_irq: got %b expected 0", irq); end
  endtask

  task automatic test_prescale();
    wr(1, 5'd2, 16'd2);
    wr(1, 5'd3, 16'd0);
    @(negedge clk);
    while (((cyc + 1) % 4) != 0) @(negedge clk);
    address = 5'd1; writedata = 16'h0004; write_n = 1'b0; cs4 = 1'b1;
    @(posedge clk); #1;
    write_n = 1'b1; cs4 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wr(1, 5'd4, 16'h0000);
      rd(5'd4);
      checks++; if (readdata4 !== exp_snap[k]) begin errors++; $display("FAIL prescale_snap%0d: got %h expected %h", k, readdata4, exp_snap[k]); end
    end
    rd(5'd0);
    checks++; if (readdata4 !== 16'h0001) begin errors++; $display("FAIL prescale_status: got %h expected %h", readdata4, 16'h0001); end
    checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL prescale_irq_masked: got %b expected 0", irq4); end
  endtask

  task automatic test_period_h();
    wr(0, 5'd26, 16'h1234);
    wr(0, 5'd25, 16'h0006);
    repeat (5) @(posedge clk);
    wr(0, 5'd27, 16'h0001);
    @(posedge clk);
    rd(5'd24);
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL periodh_run_cleared: got %h expected %h", readdata, 16'h0000); end
    wr(0, 5'd28, 16'h0000);
    rd(5'd28);
    checks++; if (readdata !== 16'h1234) begin errors++; $display("FAIL periodh_snap_l: got %h expected %h", readdata, 16'h1234); end
    rd(5'd29);
    checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL periodh_snap_h: got %h expected %h", readdata, 16'h0001); end
    wr(0, 5'd25, 16'h000C);
    rd(5'd24);
    checks++; if (readdata !== 16'h0002) begin errors++; $display("FAIL start_wins_stop: got %h expected %h", readdata, 16'h0002); end
  endtask

  task automatic test_start_reload();
    wr(0, 5'd26, 16'h0005);
    wr(0, 5'd25, 16'h0004);
    rd(5'd24);
    checks++; if (readdata !== 16'h0002) begin errors++; $display("FAIL start_reload_run: got %h expected %h", readdata, 16'h0002); end
    wr(0, 5'd28, 16'h0000);
    rd(5'd28);
    checks++; if (readdata !== 16'h0004) begin errors++; $display("FAIL start_reload_snap_l: got %h expected %h", readdata, 16'h0004); end
    rd(5'd29);
    checks++; if (readdata !== 16'h0001) begin errors++; $display("FAIL start_reload_snap_h: got %h expected %h", readdata, 16'h0001); end
    wr(0, 5'd25, 16'h0008);
  endtask

  task automatic test_reset_mid();
    wr(0, 5'd1, 16'h0007);
    wr(0, 5'd17, 16'h0007);
    wr(1, 5'd1, 16'h0007);
    repeat (8) @(posedge clk); #1;
    checks++; if (irq !== 1'b1 || irq4 !== 1'b1) begin errors++; $display("FAIL mid_pre_irq: got %b/%b expected 1/1", irq, irq4); end
    rd(5'd2);
    checks++; if (readdata !== 16'hC34F) begin errors++; $display("FAIL mid_pre_read: got %h expected %h", readdata, 16'hC34F); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL mid_readdata: got %h expected %h", readdata, 16'h0000); end
    checks++; if (irq_vec !== 4'b0 || irq !== 1'b0 || irq4 !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b/%b/%b expected 0000/0/0", irq_vec, irq, irq4); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(posedge clk); #1;
    checks++; if (irq_vec !== 4'b0 || irq !== 1'b0 || irq_vec4 !== 4'b0) begin errors++; $display("FAIL post_irq: got %b/%b/%b expected 0000/0/0000", irq_vec, irq, irq_vec4); end
    rd(5'd16);
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL post_status: got %h expected %h", readdata, 16'h0000); end
    rd(5'd18);
    checks++; if (readdata !== 16'hC34F) begin errors++; $display("FAIL post_period: got %h expected %h", readdata, 16'hC34F); end
    rd(5'd1);
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL post_control: got %h expected %h", readdata, 16'h0000); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_prescale();
    test_period_h();
    test_start_reload();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
